// File: rtl/id_operand_interlock_if.sv
// Bundle between the decode stage, the downstream forwarding slots, writeback and EX
// for id_operand_interlock.
//   master : upstream/testbench side. It drives the ID instruction, forward slots,
//            writeback, ex_allowin and flush, and observes the EX register.
//   slave  : id_operand_interlock side.
//   stall_cnt is present only when MYCPU_STALL_CNT_EN is defined.
interface id_operand_interlock_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned FWD_DEPTH = 3
);
  // ID-stage instruction
  logic                        id_valid;
  logic [AW-1:0]               id_rs;
  logic [AW-1:0]               id_rt;
  logic                        id_use_rs;
  logic                        id_use_rt;
  logic [AW-1:0]               id_dest;
  logic                        id_wen;
  logic                        id_late;
  logic                        id_allowin;
  // forwarding slots, slot 0 youngest
  logic [FWD_DEPTH-1:0]        fwd_valid;
  logic [FWD_DEPTH*AW-1:0]     fwd_dest;
  logic [FWD_DEPTH-1:0]        fwd_rdy;
  logic [FWD_DEPTH*DATA_W-1:0] fwd_data;
  // writeback port
  logic                        rf_wen;
  logic [AW-1:0]               rf_waddr;
  logic [DATA_W-1:0]           rf_wdata;
  // EX stage
  logic                        ex_allowin;
  logic                        flush;
  logic                        ex_valid;
  logic [DATA_W-1:0]           ex_rs_data;
  logic [DATA_W-1:0]           ex_rt_data;
  logic [AW-1:0]               ex_dest;
  logic                        ex_wen;
  logic                        ex_late;
  logic                        stall;
`ifdef MYCPU_STALL_CNT_EN
  logic [31:0]                 stall_cnt;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wen, id_late,
    output fwd_valid, fwd_dest, fwd_rdy, fwd_data,
    output rf_wen, rf_waddr, rf_wdata,
    output ex_allowin, flush,
    input  id_allowin, ex_valid, ex_rs_data, ex_rt_data, ex_dest, ex_wen, ex_late, stall
`ifdef MYCPU_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wen, id_late,
    input  fwd_valid, fwd_dest, fwd_rdy, fwd_data,
    input  rf_wen, rf_waddr, rf_wdata,
    input  ex_allowin, flush,
    output id_allowin, ex_valid, ex_rs_data, ex_rt_data, ex_dest, ex_wen, ex_late, stall
`ifdef MYCPU_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/id_operand_interlock.sv
// Decode-stage operand unit. It holds the register file (write-through, r0 = 0) and
// resolves rs/rt through an N-slot forwarding network with a load-use interlock. It
// also holds the ID->EX pipeline register with a valid/allowin handshake, flush and
// bubble insertion.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset. It clears the EX register and the stall
//         counter. The register file is not cleared.
//   bus : id_operand_interlock_if.slave, carrying the ID instruction, forward slots,
//         writeback, and the EX register outputs/handshake.
//         id_allowin and stall are combinational.
// Optional: define MYCPU_STALL_CNT_EN to add the saturating 32-bit bus.stall_cnt.
module id_operand_interlock #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned FWD_DEPTH = 3
) (
  input logic                   clk,
  input logic                   rst,
  id_operand_interlock_if.slave bus
);

  localparam int unsigned NREG = 1 << AW;

  logic [DATA_W-1:0] rf_q [NREG];

  logic [DATA_W-1:0] rs_rf, rt_rf;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              rs_found, rt_found;
  logic              hazard_rs, hazard_rt;
  logic              stall, id_allowin, fire;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_rs_q, ex_rs_d;
  logic [DATA_W-1:0] ex_rt_q, ex_rt_d;
  logic [AW-1:0]     ex_dest_q, ex_dest_d;
  logic              ex_wen_q, ex_wen_d;
  logic              ex_late_q, ex_late_d;

  // Register file write. Writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (bus.rf_wen && (bus.rf_waddr != '0)) begin
      rf_q[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  // Combinational read with write-through bypass of the same-cycle writeback.
  always_comb begin
    if (bus.id_rs == '0) begin
      rs_rf = '0;
    end else if (bus.rf_wen && (bus.rf_waddr == bus.id_rs)) begin
      rs_rf = bus.rf_wdata;
    end else begin
      rs_rf = rf_q[bus.id_rs];
    end
    if (bus.id_rt == '0) begin
      rt_rf = '0;
    end else if (bus.rf_wen && (bus.rf_waddr == bus.id_rt)) begin
      rt_rf = bus.rf_wdata;
    end else begin
      rt_rf = rf_q[bus.id_rt];
    end
  end

  // Forwarding scan: the first (youngest) matching slot decides the operand.
  // If that slot's result is not ready yet, the source is hazarded, even when an
  // older slot has a ready value.
  always_comb begin
    rs_found  = 1'b0;
    rt_found  = 1'b0;
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    rs_val    = rs_rf;
    rt_val    = rt_rf;
    for (int i = 0; i < int'(FWD_DEPTH); i++) begin
      if (!rs_found && bus.fwd_valid[i] && (bus.id_rs != '0) &&
          (bus.fwd_dest[i*AW +: AW] == bus.id_rs)) begin
        rs_found  = 1'b1;
        hazard_rs = ~bus.fwd_rdy[i];
        rs_val    = bus.fwd_data[i*DATA_W +: DATA_W];
      end
      if (!rt_found && bus.fwd_valid[i] && (bus.id_rt != '0) &&
          (bus.fwd_dest[i*AW +: AW] == bus.id_rt)) begin
        rt_found  = 1'b1;
        hazard_rt = ~bus.fwd_rdy[i];
        rt_val    = bus.fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Interlock and handshake
  always_comb begin
    stall      = bus.id_valid & ((bus.id_use_rs & hazard_rs) | (bus.id_use_rt & hazard_rt));
    id_allowin = ~stall & (bus.ex_allowin | ~ex_valid_q);
    fire       = bus.id_valid & id_allowin;
  end

  // EX register next state. Flush beats fire. A drained slot with no fire
  // becomes a bubble.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_dest_d  = ex_dest_q;
    ex_wen_d   = ex_wen_q;
    ex_late_d  = ex_late_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
      ex_wen_d   = 1'b0;
    end else if (fire) begin
      ex_valid_d = 1'b1;
      ex_rs_d    = rs_val;
      ex_rt_d    = rt_val;
      ex_dest_d  = bus.id_dest;
      ex_wen_d   = bus.id_wen;
      ex_late_d  = bus.id_late;
    end else if (bus.ex_allowin) begin
      ex_valid_d = 1'b0;
      ex_wen_d   = 1'b0;
    end
  end

  // EX register state
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_dest_q  <= '0;
      ex_wen_q   <= 1'b0;
      ex_late_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_dest_q  <= ex_dest_d;
      ex_wen_q   <= ex_wen_d;
      ex_late_q  <= ex_late_d;
    end
  end

  assign bus.stall      = stall;
  assign bus.id_allowin = id_allowin;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_rs_data = ex_rs_q;
  assign bus.ex_rt_data = ex_rt_q;
  assign bus.ex_dest    = ex_dest_q;
  assign bus.ex_wen     = ex_wen_q;
  assign bus.ex_late    = ex_late_q;

`ifdef MYCPU_STALL_CNT_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_operand_interlock.sv
// Directed bench for id_operand_interlock with default parameters (32/5/3).
module tb_id_operand_interlock;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_operand_interlock_if #(.DATA_W(32), .AW(5), .FWD_DEPTH(3)) bus ();

  id_operand_interlock #(.DATA_W(32), .AW(5), .FWD_DEPTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    bus.id_valid   = 1'b0;
    bus.id_rs      = '0;
    bus.id_rt      = '0;
    bus.id_use_rs  = 1'b0;
    bus.id_use_rt  = 1'b0;
    bus.id_dest    = '0;
    bus.id_wen     = 1'b0;
    bus.id_late    = 1'b0;
    bus.fwd_valid  = '0;
    bus.fwd_dest   = '0;
    bus.fwd_rdy    = '0;
    bus.fwd_data   = '0;
    bus.rf_wen     = 1'b0;
    bus.rf_waddr   = '0;
    bus.rf_wdata   = '0;
    bus.ex_allowin = 1'b1;
    bus.flush      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%h exp=0", bus.ex_valid); end
    total++; if (bus.ex_rs_data !== 32'h0) begin bad++; $display("FAIL reset_ex_rs got=%h exp=0", bus.ex_rs_data); end
    total++; if (bus.ex_rt_data !== 32'h0) begin bad++; $display("FAIL reset_ex_rt got=%h exp=0", bus.ex_rt_data); end
    total++; if (bus.ex_dest !== 5'd0 || bus.ex_wen !== 1'b0 || bus.ex_late !== 1'b0) begin
      bad++; $display("FAIL reset_ex_ctl got=%h/%h/%h exp=0/0/0", bus.ex_dest, bus.ex_wen, bus.ex_late); end
    total++; if (bus.stall !== 1'b0 || bus.id_allowin !== 1'b1) begin
      bad++; $display("FAIL reset_hs stall/allowin got=%h/%h exp=0/1", bus.stall, bus.id_allowin); end
  endtask

  task automatic test_regfile();
    @(negedge clk);
    clear_in();
    bus.rf_wen = 1'b1; bus.rf_waddr = 5'd5; bus.rf_wdata = 32'hDEADBEEF;
    tick();
    @(negedge clk);
    clear_in();
    bus.id_valid = 1'b1; bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
    bus.id_dest = 5'd9; bus.id_wen = 1'b1; bus.id_late = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0 || bus.id_allowin !== 1'b1) begin
      bad++; $display("FAIL rf_hs stall/allowin got=%h/%h exp=0/1", bus.stall, bus.id_allowin); end
    tick();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL rf_ex_valid got=%h exp=1", bus.ex_valid); end
    total++; if (bus.ex_rs_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rf_ex_rs got=%h exp=deadbeef", bus.ex_rs_data); end
    total++; if (bus.ex_dest !== 5'd9 || bus.ex_wen !== 1'b1 || bus.ex_late !== 1'b1) begin
      bad++; $display("FAIL rf_ex_ctl got=%h/%h/%h exp=09/1/1", bus.ex_dest, bus.ex_wen, bus.ex_late); end
    @(negedge clk);
    clear_in();
    tick();
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_wen !== 1'b0) begin
      bad++; $display("FAIL bubble valid/wen got=%h/%h exp=0/0", bus.ex_valid, bus.ex_wen); end
  endtask

  task automatic test_write_through();
    @(negedge clk);
    clear_in();
    bus.rf_wen = 1'b1; bus.rf_waddr = 5'd6; bus.rf_wdata = 32'hCAFE0006;
    bus.id_valid = 1'b1; bus.id_rs = 5'd6; bus.id_rt = 5'd6;
    bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1; bus.id_dest = 5'd1;
    tick();
    total++; if (bus.ex_rs_data !== 32'hCAFE0006 || bus.ex_rt_data !== 32'hCAFE0006) begin
      bad++; $display("FAIL wthru rs/rt got=%h/%h exp=cafe0006", bus.ex_rs_data, bus.ex_rt_data); end
  endtask

  task automatic test_youngest();
    @(negedge clk);
    clear_in();
    bus.fwd_valid = 3'b101; bus.fwd_rdy = 3'b111;
    bus.fwd_dest  = {5'd5, 5'd0, 5'd5};
    bus.fwd_data  = {32'h33, 32'h0, 32'h11};
    bus.id_valid = 1'b1; bus.id_rs = 5'd5; bus.id_rt = 5'd5;
    bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
    tick();
    total++; if (bus.ex_rs_data !== 32'h11 || bus.ex_rt_data !== 32'h11) begin
      bad++; $display("FAIL young_slot0 rs/rt got=%h/%h exp=11/11", bus.ex_rs_data, bus.ex_rt_data); end
    @(negedge clk);
    clear_in();
    bus.fwd_valid = 3'b110; bus.fwd_rdy = 3'b111;
    bus.fwd_dest  = {5'd7, 5'd7, 5'd0};
    bus.fwd_data  = {32'h33, 32'h22, 32'h0};
    bus.id_valid = 1'b1; bus.id_rs = 5'd7; bus.id_rt = 5'd5;
    bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
    tick();
    total++; if (bus.ex_rs_data !== 32'h22 || bus.ex_rt_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL young_slot1 rs/rt got=%h/%h exp=22/deadbeef", bus.ex_rs_data, bus.ex_rt_data); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_in();
    bus.fwd_valid = 3'b001; bus.fwd_dest = {5'd0, 5'd0, 5'd7}; bus.fwd_rdy = 3'b000;
    bus.id_valid = 1'b1; bus.id_rs = 5'd5; bus.id_rt = 5'd7;
    bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1; bus.id_dest = 5'd8; bus.id_wen = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b1 || bus.id_allowin !== 1'b0) begin
      bad++; $display("FAIL lu_stall stall/allowin got=%h/%h exp=1/0", bus.stall, bus.id_allowin); end
    tick();
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_wen !== 1'b0) begin
      bad++; $display("FAIL lu_bubble valid/wen got=%h/%h exp=0/0", bus.ex_valid, bus.ex_wen); end
    @(negedge clk);
    bus.fwd_rdy = 3'b001; bus.fwd_data = {32'h0, 32'h0, 32'h55};
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_release stall got=%h exp=0", bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_rt_data !== 32'h55 || bus.ex_rs_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lu_fire valid/rt/rs got=%h/%h/%h exp=1/55/deadbeef", bus.ex_valid, bus.ex_rt_data, bus.ex_rs_data); end
    // a younger not-ready slot hides an older ready one
    @(negedge clk);
    clear_in();
    bus.fwd_valid = 3'b011; bus.fwd_dest = {5'd0, 5'd7, 5'd7}; bus.fwd_rdy = 3'b010;
    bus.fwd_data = {32'h0, 32'h77, 32'h0};
    bus.id_valid = 1'b1; bus.id_rt = 5'd7; bus.id_use_rt = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_mask stall got=%h exp=1", bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL lu_mask ex_valid got=%h exp=0", bus.ex_valid); end
  endtask

  task automatic test_no_use();
    @(negedge clk);
    clear_in();
    bus.fwd_valid = 3'b001; bus.fwd_dest = {5'd0, 5'd0, 5'd7}; bus.fwd_rdy = 3'b000;
    bus.id_valid = 1'b1; bus.id_rs = 5'd5; bus.id_rt = 5'd7;
    bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL nouse stall got=%h exp=0", bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_rs_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL nouse fire valid/rs got=%h/%h exp=1/deadbeef", bus.ex_valid, bus.ex_rs_data); end
    @(negedge clk);
    bus.id_valid = 1'b0; bus.id_use_rt = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL novalid stall got=%h exp=0", bus.stall); end
    tick();
  endtask

  task automatic test_zero_src();
    @(negedge clk);
    clear_in();
    bus.rf_wen = 1'b1; bus.rf_waddr = 5'd0; bus.rf_wdata = 32'hFFFFFFFF;
    bus.fwd_valid = 3'b001; bus.fwd_dest = '0; bus.fwd_rdy = 3'b001;
    bus.fwd_data = {32'h0, 32'h0, 32'h99};
    bus.id_valid = 1'b1; bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL zero stall got=%h exp=0", bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_rs_data !== 32'h0 || bus.ex_rt_data !== 32'h0) begin
      bad++; $display("FAIL zero operands valid/rs/rt got=%h/%h/%h exp=1/0/0", bus.ex_valid, bus.ex_rs_data, bus.ex_rt_data); end
    @(negedge clk);
    bus.rf_wen = 1'b0; bus.fwd_rdy = 3'b000;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL zero_notrdy stall got=%h exp=0", bus.stall); end
    tick();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    clear_in();
    bus.id_valid = 1'b1; bus.id_rs = 5'd5; bus.id_use_rs = 1'b1; bus.id_dest = 5'd10; bus.id_wen = 1'b1;
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd10) begin
      bad++; $display("FAIL b2b_first valid/dest got=%h/%h exp=1/0a", bus.ex_valid, bus.ex_dest); end
    @(negedge clk);
    bus.ex_allowin = 1'b0; bus.id_rs = 5'd6; bus.id_dest = 5'd11;
    #1;
    total++; if (bus.id_allowin !== 1'b0 || bus.stall !== 1'b0) begin
      bad++; $display("FAIL hold allowin/stall got=%h/%h exp=0/0", bus.id_allowin, bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd10 || bus.ex_rs_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL hold regs valid/dest/rs got=%h/%h/%h exp=1/0a/deadbeef", bus.ex_valid, bus.ex_dest, bus.ex_rs_data); end
    @(negedge clk);
    bus.ex_allowin = 1'b1;
    tick();
    total++; if (bus.ex_dest !== 5'd11 || bus.ex_rs_data !== 32'hCAFE0006) begin
      bad++; $display("FAIL b2b_second dest/rs got=%h/%h exp=0b/cafe0006", bus.ex_dest, bus.ex_rs_data); end
    @(negedge clk);
    bus.id_rs = 5'd5; bus.id_dest = 5'd12;
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd12 || bus.ex_rs_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL b2b_third valid/dest/rs got=%h/%h/%h exp=1/0c/deadbeef", bus.ex_valid, bus.ex_dest, bus.ex_rs_data); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    clear_in();
    bus.flush = 1'b1;
    bus.id_valid = 1'b1; bus.id_rs = 5'd5; bus.id_use_rs = 1'b1; bus.id_dest = 5'd13; bus.id_wen = 1'b1;
    tick();
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_wen !== 1'b0) begin
      bad++; $display("FAIL flush_fire valid/wen got=%h/%h exp=0/0", bus.ex_valid, bus.ex_wen); end
    @(negedge clk);
    bus.flush = 1'b0; bus.ex_allowin = 1'b0; bus.id_dest = 5'd14;
    #1;
    total++; if (bus.id_allowin !== 1'b1) begin bad++; $display("FAIL empty_allowin got=%h exp=1", bus.id_allowin); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd14 || bus.ex_wen !== 1'b1) begin
      bad++; $display("FAIL refill valid/dest/wen got=%h/%h/%h exp=1/0e/1", bus.ex_valid, bus.ex_dest, bus.ex_wen); end
    @(negedge clk);
    bus.flush = 1'b1; bus.id_valid = 1'b0;
    tick();
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_wen !== 1'b0) begin
      bad++; $display("FAIL flush_held valid/wen got=%h/%h exp=0/0", bus.ex_valid, bus.ex_wen); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clear_in();
    bus.id_valid = 1'b1; bus.id_rs = 5'd6; bus.id_use_rs = 1'b1;
    bus.id_dest = 5'd15; bus.id_wen = 1'b1; bus.id_late = 1'b1;
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_late !== 1'b1 || bus.ex_rs_data !== 32'hCAFE0006) begin
      bad++; $display("FAIL pre_rst valid/late/rs got=%h/%h/%h exp=1/1/cafe0006", bus.ex_valid, bus.ex_late, bus.ex_rs_data); end
    @(negedge clk);
    rst = 1'b1;
    bus.id_rt = 5'd7; bus.id_use_rt = 1'b1;
    bus.fwd_valid = 3'b001; bus.fwd_dest = {5'd0, 5'd0, 5'd7}; bus.fwd_rdy = 3'b000;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rst_stall got=%h exp=1", bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_rs_data !== 32'h0 || bus.ex_rt_data !== 32'h0 ||
                 bus.ex_dest !== 5'd0 || bus.ex_wen !== 1'b0 || bus.ex_late !== 1'b0) begin
      bad++; $display("FAIL rst_mid valid/rs/rt/dest/wen/late got=%h/%h/%h/%h/%h/%h exp=all 0",
                      bus.ex_valid, bus.ex_rs_data, bus.ex_rt_data, bus.ex_dest, bus.ex_wen, bus.ex_late); end
    @(negedge clk);
    rst = 1'b0;
    clear_in();
  endtask

`ifdef MYCPU_STALL_CNT_EN
  task automatic test_stall_cnt();
    #1;
    total++; if (bus.stall_cnt !== 32'd0) begin bad++; $display("FAIL cnt_after_rst got=%0d exp=0", bus.stall_cnt); end
    @(negedge clk);
    clear_in();
    bus.id_valid = 1'b1; bus.id_rt = 5'd7; bus.id_use_rt = 1'b1;
    bus.fwd_valid = 3'b001; bus.fwd_dest = {5'd0, 5'd0, 5'd7}; bus.fwd_rdy = 3'b000;
    repeat (3) tick();
    @(negedge clk);
    clear_in();
    tick();
    total++; if (bus.stall_cnt !== 32'd3) begin bad++; $display("FAIL cnt_three got=%0d exp=3", bus.stall_cnt); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_in();
    repeat (3) @(posedge clk);
    test_reset();
    test_regfile();
    test_write_through();
    test_youngest();
    test_load_use();
    test_no_use();
    test_zero_src();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef MYCPU_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
